// File: rtl/ntt_pkg.sv
// ntt_pkg: definitions shared by the NTT command scheduler and its FIFO.
//   - conf codes driven to the NTT index/control FSM
//   - host opcodes (0 is reserved as illegal)
//   - done_flag masks that retire each operation
//   - scheduler state encoding
//   - helpers that map an opcode to its run / drain conf code and done mask
package ntt_pkg;

  typedef enum logic [2:0] {
    CONF_IDLE      = 3'd0,
    CONF_NTT       = 3'd1,
    CONF_PWM       = 3'd2,
    CONF_INTT      = 3'd3,
    CONF_DONE_NTT  = 3'd4,
    CONF_DONE_INTT = 3'd5
  } conf_e;

  typedef enum logic [1:0] {
    OP_ILLEGAL = 2'd0,
    OP_NTT     = 2'd1,
    OP_PWM     = 2'd2,
    OP_INTT    = 2'd3
  } op_e;

  localparam logic [3:0] DONE_MASK_NTT  = 4'b0001;
  localparam logic [3:0] DONE_MASK_PWM  = 4'b0010;
  localparam logic [3:0] DONE_MASK_INTT = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_GAP   = 2'd3
  } sched_state_e;

  // done_flag pattern that retires a given opcode
  function automatic logic [3:0] done_mask(input op_e op);
    logic [3:0] m;
    case (op)
      OP_NTT:  m = DONE_MASK_NTT;
      OP_PWM:  m = DONE_MASK_PWM;
      OP_INTT: m = DONE_MASK_INTT;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // conf code presented while an opcode is running
  function automatic logic [2:0] run_conf(input op_e op);
    logic [2:0] c;
    case (op)
      OP_NTT:  c = CONF_NTT;
      OP_PWM:  c = CONF_PWM;
      OP_INTT: c = CONF_INTT;
      default: c = CONF_IDLE;
    endcase
    return c;
  endfunction

  // conf code held while the write-enable pipeline drains; PWM shares DONE_NTT
  function automatic logic [2:0] drain_conf(input op_e op);
    logic [2:0] c;
    case (op)
      OP_INTT: c = CONF_DONE_INTT;
      default: c = CONF_DONE_NTT;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: small synchronous FIFO holding queued scheduler opcodes.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   push, wdata         write request (ignored when full)
//   pop                 read request (ignored when empty)
//   rdata               head entry, valid whenever empty is low
//   not_full            registered "space available" flag
//   empty               registered empty flag
//   empty_nxt           empty flag as it will be after this edge
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             not_full,
  output logic             empty,
  output logic             empty_nxt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             not_full_q, not_full_d;
  logic             empty_q, empty_d;
  logic             push_ok;
  logic             pop_ok;

  // Next-state for storage, pointers and registered flags
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    // Gating on registered flags only keeps pop off the cmd_ready path
    push_ok    = push && not_full_q;
    pop_ok     = pop && !empty_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? AW'(0) : wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? AW'(0) : rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    not_full_d = (count_d != CW'(DEPTH));
    empty_d    = (count_d == CW'(0));
  end

  // FIFO state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= AW'(0);
      rd_ptr_q   <= AW'(0);
      count_q    <= CW'(0);
      not_full_q <= 1'b1;
      empty_q    <= 1'b1;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      not_full_q <= not_full_d;
      empty_q    <= empty_d;
    end
  end

  assign rdata     = mem_q[rd_ptr_q];
  assign not_full  = not_full_q;
  assign empty     = empty_q;
  assign empty_nxt = empty_d;

endmodule

// File: rtl/ntt_op_scheduler.sv
// ntt_op_scheduler: queues NTT / PWM / INTT requests and sequences the NTT
// control FSM through RUN -> DRAIN -> GAP for each, retiring on done_flag.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cmd_valid, cmd_op   command offer (op 1=NTT 2=PWM 3=INTT 0=illegal)
//   cmd_ready           command FIFO has space
//   conf                control code to the FSM
//   done_flag           completion pattern from the FSM
//   busy                an op is in flight or commands are queued
//   rsp_valid           one-cycle completion pulse
//   rsp_op, rsp_err     retired opcode and timeout/illegal error
//   rsp_cycles          RUN cycles consumed by the retired op
// All outputs are registered.
module ntt_op_scheduler #(
  parameter int DEPTH     = 4,
  parameter int DRAIN_CYC = 8,
  parameter int MAX_CYC   = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  output logic        cmd_ready,
  output logic [2:0]  conf,
  input  logic [3:0]  done_flag,
  output logic        busy,
  output logic        rsp_valid,
  output logic [1:0]  rsp_op,
  output logic        rsp_err,
  output logic [11:0] rsp_cycles
);

  import ntt_pkg::*;

  localparam int DW = $clog2(DRAIN_CYC + 1);
  localparam logic [11:0] CYC_SAT = 12'hFFF;

  sched_state_e   state_q, state_d;
  op_e            op_q, op_d;
  logic [11:0]    cyc_q, cyc_d;
  logic [DW-1:0]  drain_q, drain_d;
  logic           err_q, err_d;
  logic [2:0]     conf_q, conf_d;
  logic           busy_q, busy_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [1:0]     rsp_op_q, rsp_op_d;
  logic           rsp_err_q, rsp_err_d;
  logic [11:0]    rsp_cycles_q, rsp_cycles_d;

  logic           fifo_pop;
  logic [1:0]     fifo_rdata;
  logic           fifo_not_full;
  logic           fifo_empty;
  logic           fifo_empty_nxt;
  logic           done_hit;
  op_e            head_op;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid),
    .wdata     (cmd_op),
    .pop       (fifo_pop),
    .rdata     (fifo_rdata),
    .not_full  (fifo_not_full),
    .empty     (fifo_empty),
    .empty_nxt (fifo_empty_nxt)
  );

  // Scheduler next-state, counters, response capture and conf decode
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    cyc_d        = cyc_q;
    drain_d      = drain_q;
    err_d        = err_q;
    rsp_valid_d  = 1'b0;
    rsp_op_d     = rsp_op_q;
    rsp_err_d    = rsp_err_q;
    rsp_cycles_d = rsp_cycles_q;
    fifo_pop     = 1'b0;
    head_op      = op_e'(fifo_rdata);
    // Only the exact mask of the running op retires it
    done_hit     = (op_q != OP_ILLEGAL) && (done_flag == done_mask(op_q));

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_op == OP_ILLEGAL) begin
            // Reject in place: respond next cycle, conf never leaves IDLE
            rsp_valid_d  = 1'b1;
            rsp_op_d     = 2'd0;
            rsp_err_d    = 1'b1;
            rsp_cycles_d = 12'd0;
          end else begin
            op_d    = head_op;
            cyc_d   = 12'd1;
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // A match wins over a coincident timeout
        if (done_hit) begin
          err_d   = 1'b0;
          drain_d = DW'(DRAIN_CYC - 1);
          state_d = ST_DRAIN;
        end else if (cyc_q == 12'(MAX_CYC)) begin
          err_d   = 1'b1;
          drain_d = DW'(DRAIN_CYC - 1);
          state_d = ST_DRAIN;
        end else begin
          cyc_d = (cyc_q == CYC_SAT) ? cyc_q : cyc_q + 12'd1;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DW'(0)) begin
          // Response becomes visible during the GAP cycle
          state_d      = ST_GAP;
          rsp_valid_d  = 1'b1;
          rsp_op_d     = op_q;
          rsp_err_d    = err_q;
          rsp_cycles_d = cyc_q;
        end else begin
          drain_d = drain_q - DW'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // conf is decoded from the next state so it changes on the same edge
    case (state_d)
      ST_RUN:   conf_d = run_conf(op_d);
      ST_DRAIN: conf_d = drain_conf(op_d);
      default:  conf_d = CONF_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) || !fifo_empty_nxt;
  end

  // Scheduler state and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_ILLEGAL;
      cyc_q        <= 12'd0;
      drain_q      <= DW'(0);
      err_q        <= 1'b0;
      conf_q       <= 3'd0;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_op_q     <= 2'd0;
      rsp_err_q    <= 1'b0;
      rsp_cycles_q <= 12'd0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      cyc_q        <= cyc_d;
      drain_q      <= drain_d;
      err_q        <= err_d;
      conf_q       <= conf_d;
      busy_q       <= busy_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_op_q     <= rsp_op_d;
      rsp_err_q    <= rsp_err_d;
      rsp_cycles_q <= rsp_cycles_d;
    end
  end

  assign cmd_ready  = fifo_not_full;
  assign conf       = conf_q;
  assign busy       = busy_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_cycles = rsp_cycles_q;

endmodule

// File: tb/tb_ntt_op_scheduler.sv
// tb_ntt_op_scheduler: directed bench for ntt_op_scheduler with an FSM stub
// driven from the stimulus (done_flag raised on chosen RUN cycles).
module tb_ntt_op_scheduler;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic        cmd_ready;
  logic [2:0]  conf;
  logic [3:0]  done_flag;
  logic        busy;
  logic        rsp_valid;
  logic [1:0]  rsp_op;
  logic        rsp_err;
  logic [11:0] rsp_cycles;

  int n_vec;
  int n_err;

  ntt_op_scheduler #(
    .DEPTH     (4),
    .DRAIN_CYC (8),
    .MAX_CYC   (4095)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_ready  (cmd_ready),
    .conf       (conf),
    .done_flag  (done_flag),
    .busy       (busy),
    .rsp_valid  (rsp_valid),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err),
    .rsp_cycles (rsp_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [1:0] op);
    cmd_valid = 1'b1;
    cmd_op    = op;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Entered on a RUN cycle of op; returns on the IDLE cycle after GAP.
  task automatic run_and_check(input logic [1:0] op, input int match_at, input logic [3:0] flag,
                               input int bad_at, input logic [3:0] bad_flag,
                               input logic [2:0] drain_code, input logic exp_err,
                               input int exp_len, input logic [11:0] exp_cyc);
    int run_len;
    int drain_len;
    int rsp_early;
    run_len   = 0;
    drain_len = 0;
    rsp_early = 0;
    check_val("run_start_conf", {29'd0, conf}, {30'd0, op});
    while ((conf == {1'b0, op}) && (run_len < 5000)) begin
      run_len++;
      if (run_len == match_at) done_flag = flag;
      else if (run_len == bad_at) done_flag = bad_flag;
      else done_flag = 4'b0000;
      tick();
    end
    done_flag = 4'b0000;
    check_val("run_len", run_len, exp_len);
    while ((conf == drain_code) && (drain_len < 20)) begin
      drain_len++;
      if (rsp_valid) rsp_early++;
      // the real FSM shows 0001 while in DONE_INTT; it must not matter
      done_flag = (drain_code == 3'd5) ? 4'b0001 : 4'b0000;
      tick();
    end
    done_flag = 4'b0000;
    check_val("drain_len", drain_len, 8);
    check_val("rsp_early", rsp_early, 0);
    check_val("gap_conf", {29'd0, conf}, 0);
    check_val("gap_rsp_valid", {31'd0, rsp_valid}, 1);
    check_val("gap_rsp_op", {30'd0, rsp_op}, {30'd0, op});
    check_val("gap_rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    check_val("gap_rsp_cycles", {20'd0, rsp_cycles}, {20'd0, exp_cyc});
    tick();
    check_val("post_rsp_valid", {31'd0, rsp_valid}, 0);
    check_val("post_conf", {29'd0, conf}, 0);
    check_val("post_rsp_op_hold", {30'd0, rsp_op}, {30'd0, op});
  endtask

  initial begin
    logic [1:0] ops [5];
    int acc;
    int guard;
    int waited;

    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    done_flag = 4'b0000;
    ops[0] = 2'd2; ops[1] = 2'd3; ops[2] = 2'd1; ops[3] = 2'd2; ops[4] = 2'd3;

    // reset values
    tick(); tick();
    check_val("rst_conf", {29'd0, conf}, 0);
    check_val("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    check_val("rst_busy", {31'd0, busy}, 0);
    check_val("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    check_val("rst_rsp_op", {30'd0, rsp_op}, 0);
    check_val("rst_rsp_err", {31'd0, rsp_err}, 0);
    check_val("rst_rsp_cycles", {20'd0, rsp_cycles}, 0);
    rst_n = 1'b1;
    tick();

    // NTT run, match on RUN cycle 2561
    push_cmd(2'd1);
    check_val("ntt_accept_conf", {29'd0, conf}, 0);
    check_val("ntt_accept_busy", {31'd0, busy}, 1);
    tick();
    run_and_check(2'd1, 2561, 4'b0001, 0, 4'b0000, 3'd4, 1'b0, 2561, 12'd2561);

    // back-to-back INTT, PWM, NTT
    cmd_valid = 1'b1;
    cmd_op = 2'd3; check_val("b2b_ready0", {31'd0, cmd_ready}, 1); tick();
    cmd_op = 2'd2; check_val("b2b_ready1", {31'd0, cmd_ready}, 1); tick();
    cmd_op = 2'd1; check_val("b2b_ready2", {31'd0, cmd_ready}, 1); tick();
    cmd_valid = 1'b0;
    // now on INTT RUN cycle 2; 0001 during INTT must be ignored
    run_and_check(2'd3, 5, 4'b0100, 2, 4'b0001, 3'd5, 1'b0, 5, 12'd6);
    tick();
    run_and_check(2'd2, 3, 4'b0010, 1, 4'b0100, 3'd4, 1'b0, 3, 12'd3);
    tick();
    run_and_check(2'd1, 4, 4'b0001, 2, 4'b0010, 3'd4, 1'b0, 4, 12'd4);
    check_val("b2b_idle_busy", {31'd0, busy}, 0);

    // full FIFO while NTT is stalled in RUN
    push_cmd(2'd1);
    tick();
    check_val("stall_conf", {29'd0, conf}, 1);
    acc = 0;
    guard = 0;
    while ((acc < 4) && (guard < 20)) begin
      cmd_valid = 1'b1;
      cmd_op = ops[acc];
      if (cmd_ready) acc++;
      guard++;
      tick();
    end
    check_val("fill_cycles", guard, 4);
    cmd_op = ops[4];
    check_val("full_ready", {31'd0, cmd_ready}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("full_hold_ready", {31'd0, cmd_ready}, 0);
    end
    done_flag = 4'b0001;
    tick();
    done_flag = 4'b0000;
    waited = 0;
    while (!cmd_ready && (waited < 30)) begin
      waited++;
      tick();
    end
    check_val("full_wait", waited, 10);
    check_val("full_first_pop_conf", {29'd0, conf}, 2);
    tick();
    cmd_valid = 1'b0;
    run_and_check(2'd2, 3, 4'b0010, 0, 4'b0000, 3'd4, 1'b0, 3, 12'd4);
    tick();
    run_and_check(2'd3, 2, 4'b0100, 0, 4'b0000, 3'd5, 1'b0, 2, 12'd2);
    tick();
    run_and_check(2'd1, 2, 4'b0001, 0, 4'b0000, 3'd4, 1'b0, 2, 12'd2);
    tick();
    run_and_check(2'd2, 2, 4'b0010, 0, 4'b0000, 3'd4, 1'b0, 2, 12'd2);
    tick();
    run_and_check(2'd3, 2, 4'b0100, 0, 4'b0000, 3'd5, 1'b0, 2, 12'd2);
    check_val("full_drained_busy", {31'd0, busy}, 0);

    // PWM timeout, wrong mask 0100 on cycle 100
    push_cmd(2'd2);
    tick();
    run_and_check(2'd2, 0, 4'b0000, 100, 4'b0100, 3'd4, 1'b1, 4095, 12'd4095);

    // illegal opcode
    push_cmd(2'd0);
    check_val("ill_conf0", {29'd0, conf}, 0);
    check_val("ill_rsp_valid0", {31'd0, rsp_valid}, 0);
    tick();
    check_val("ill_conf1", {29'd0, conf}, 0);
    check_val("ill_rsp_valid1", {31'd0, rsp_valid}, 1);
    check_val("ill_rsp_err", {31'd0, rsp_err}, 1);
    check_val("ill_rsp_op", {30'd0, rsp_op}, 0);
    check_val("ill_rsp_cycles", {20'd0, rsp_cycles}, 0);
    tick();
    check_val("ill_conf2", {29'd0, conf}, 0);
    check_val("ill_rsp_valid2", {31'd0, rsp_valid}, 0);
    check_val("ill_busy", {31'd0, busy}, 0);

    // reset on RUN cycle 100 with two commands queued
    push_cmd(2'd1);
    tick();
    for (int c = 1; c < 100; c++) begin
      cmd_valid = (c <= 2);
      cmd_op = (c == 1) ? 2'd3 : 2'd2;
      tick();
    end
    cmd_valid = 1'b0;
    check_val("mid_conf", {29'd0, conf}, 1);
    check_val("mid_busy", {31'd0, busy}, 1);
    rst_n = 1'b0;
    tick();
    check_val("mrst_conf", {29'd0, conf}, 0);
    check_val("mrst_busy", {31'd0, busy}, 0);
    check_val("mrst_cmd_ready", {31'd0, cmd_ready}, 1);
    check_val("mrst_rsp_valid", {31'd0, rsp_valid}, 0);
    rst_n = 1'b1;
    tick();
    tick();
    check_val("mrst_after_conf", {29'd0, conf}, 0);
    check_val("mrst_after_busy", {31'd0, busy}, 0);
    check_val("mrst_after_rsp_valid", {31'd0, rsp_valid}, 0);
    push_cmd(2'd1);
    check_val("fresh_accept_conf", {29'd0, conf}, 0);
    tick();
    run_and_check(2'd1, 2561, 4'b0001, 0, 4'b0000, 3'd4, 1'b0, 2561, 12'd2561);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ntt_op_scheduler.md
# ntt_op_scheduler

Command scheduler that sits in front of the NTT index/control FSM. It accepts NTT, PWM and INTT requests over a valid/ready port and queues them. It drives the FSM's `conf` input through run, pipeline-drain and idle-gap phases, and watches `done_flag` to retire each operation. It reports completion, error status and run length to the host sequencer.

## Interface
- `DEPTH`, 4: command FIFO entries (power of two, ≥2).
- `DRAIN_CYC`, 8: cycles `conf` is held at a DONE code after run completion. Matches the 8-deep write-enable pipeline.
- `MAX_CYC`, 4095: RUN-cycle timeout limit; the cycle counter is 12 bits.

Ports (reset: synchronous, active-low):
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_op` in 2: opcode. 1=NTT, 2=PWM, 3=INTT, 0=illegal.
- `cmd_ready` out 1: FIFO not full.
- `conf` out 3: to FSM. 0=IDLE, 1=NTT, 2=PWM, 3=INTT, 4=DONE_NTT, 5=DONE_INTT.
- `done_flag` in 4: from FSM.
- `busy` out 1: state ≠ IDLE or FIFO non-empty.
- `rsp_valid` out 1: one-cycle completion pulse.
- `rsp_op` out 2: opcode being retired.
- `rsp_err` out 1: timeout or illegal opcode.
- `rsp_cycles` out 12: RUN cycles consumed.

## Operation
- States: IDLE, RUN, DRAIN, GAP.
- **IDLE**
  - `conf`=0.
  - If the FIFO is non-empty: pop the head.
  - Opcode 0: stay IDLE. Next cycle `rsp_valid`=1, `rsp_err`=1, `rsp_op`=0, `rsp_cycles`=0. `conf` is never changed.
  - Legal opcode: latch it and go to RUN.
- **RUN**
  - `conf`=opcode.
  - The cycle counter starts at 1 on the first RUN cycle and increments every RUN cycle, saturating at 4095.
  - Done match, checked every RUN cycle: NTT needs `done_flag`==4'b0001, PWM needs 4'b0010, INTT needs 4'b0100. Any other value, including 4'b0001 during INTT, is ignored.
  - On a match: go to DRAIN with `err`=0.
  - When the counter equals `MAX_CYC` with no match: go to DRAIN with `err`=1.
  - A match on the same cycle as the timeout counts as success (`err`=0).
- **DRAIN**
  - `conf`=4 for NTT and PWM, 5 for INTT.
  - Lasts exactly `DRAIN_CYC` cycles, counted by a down-counter, then go to GAP.
  - `done_flag` is ignored; the FSM drives 4'b0001 in DONE_INTT.
- **GAP**
  - `conf`=0 for exactly 1 cycle. This lets the FSM reload its stage index before the next op.
  - `rsp_valid` pulses in this cycle with latched `rsp_op`, `rsp_err` and `rsp_cycles`.
  - Then go to IDLE.
- **FIFO**
  - Push when `cmd_valid && cmd_ready`.
  - `cmd_ready` = !full, registered-state based only; there is no combinational path from pop.
  - Push and pop in the same cycle are both honoured; the count is unchanged.
  - Pointer wrap-around uses modulo `DEPTH`.
- `rsp_*` fields hold their last values between pulses. There is no response back-pressure; the host must sample the pulse.

## Timing
- Reset values: `conf`=0, `cmd_ready`=1, `busy`=0, `rsp_valid`=0, `rsp_op`=0, `rsp_err`=0, `rsp_cycles`=0. The FIFO is emptied and the state goes to IDLE.
- Reset asserted mid-RUN: `conf` returns to 0 on the next edge and queued commands are discarded. No response is issued.
- All outputs are registered.
- Latency from accept to first RUN cycle:
  - Empty FIFO in IDLE: 2 cycles (push edge, then pop/transition edge).
- Latency from done match to `rsp_valid`: `DRAIN_CYC`+1 cycles.
- Minimum spacing between consecutive runs: `DRAIN_CYC`+2 non-RUN cycles (DRAIN, GAP, IDLE pop).
- Nominal run lengths with the real FSM, counted from the first RUN cycle to the match, including the FSM's 1-cycle `conf` register:
  - NTT and INTT: 10 stages × 256 = 2560 cycles plus 1.
  - PWM: 256 plus 1.

## Structure
- Shared package `ntt_pkg`:
  - `conf` codes IDLE/NTT/PWM/INTT/DONE_NTT/DONE_INTT.
  - Opcode enum.
  - Done masks 4'b0001/0010/0100.
  - Scheduler state enum.
- Sub-module `cmd_fifo`: synchronous FIFO, parameters `DEPTH` and width 2, with full/empty flags.
- Scheduler FSM, counters and response registers live in `ntt_op_scheduler`.

## Test plan
- **NTT run with stub.** Push op 1; the stub raises `done_flag`=0001 on RUN cycle 2561.
  - `conf` sequence is 1×2561, then 4×8, then 0.
  - `rsp_valid` appears 9 cycles after the match, with `rsp_op`=1, `rsp_err`=0, `rsp_cycles`=2561.
- **Back-to-back queue.** Push INTT, PWM, NTT in 3 consecutive cycles (DEPTH=4).
  - `cmd_ready` stays 1.
  - Ops execute in order: INTT drains with `conf`=5, PWM drains with 4.
  - Exactly one GAP cycle with `conf`=0 occurs between each op.
- **Full FIFO.** With the scheduler stalled in RUN, push 5 commands.
  - `cmd_ready` drops after the 4th accept.
  - The 5th is held until a pop, then accepted.
  - No command is lost or duplicated.
- **Timeout.** Run PWM with `done_flag` held at 0.
  - The scheduler leaves RUN after cycle 4095.
  - Response is `rsp_err`=1, `rsp_cycles`=4095.
  - A wrong-mask `done_flag`=0100 during PWM does not end the run.
- **Illegal opcode.** Push op 0.
  - `conf` stays 0 throughout.
  - One-cycle `rsp_valid` with `rsp_err`=1, `rsp_op`=0.
- **Reset mid-run.** Drop `rst_n` on RUN cycle 100 of NTT with 2 commands queued.
  - Next cycle: `conf`=0, `busy`=0, `cmd_ready`=1, no `rsp_valid`.
  - A fresh NTT run after release behaves as in the first scenario.
